bus_master_port: RTL and testbench

Master-side serial port for the on-chip serial bus. It accepts one parallel read or write request per transaction from a local requester and serialises it onto the bus: a 15-bit address, then an address acknowledge, then 8 data bits. It drives the select line consumed by the address decoder, which feeds the slave select inputs of the 4K memory slaves, and it collects read data or write acknowledge back from the addressed slave.

---
 rtl/bus_master_port.sv | 186 ++++++++++++++++++
 tb/tb_bus_master_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// Master-side serial bus port: serialises one parallel read/write request into
// address, address-acknowledge and data phases, with acknowledge timeout abort.
module bus_master_port #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 15,
    parameter int RD_SKEW     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic                  m_rw,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_rvalid,
    output logic                  m_done,
    output logic                  m_err,
    output logic                  b_sel,
    output logic                  b_rw,
    output logic                  b_bus_out,
    input  logic                  b_bus_in,
    input  logic                  b_ack
);

    localparam int MAX_AD    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_COUNT = (MAX_AD > ACK_TIMEOUT) ? MAX_AD : ACK_TIMEOUT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] RX_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] SKEW_LAST = CW'((RD_SKEW > 0) ? (RD_SKEW - 1) : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        AACK  = 3'd2,
        WDATA = 3'd3,
        WACK  = 3'd4,
        RSKEW = 3'd5,
        RDATA = 3'd6
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic                  ack_seen_r;
    logic [ADDR_WIDTH-1:0] addr_sh_r;
    logic [DATA_WIDTH-1:0] wdata_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic                  ack_fall_s;
    logic                  ack_expire_s;

    // Handshake status for the two acknowledge states; a fall wins over expiry.
    always_comb begin
        ack_fall_s   = 1'b0;
        ack_expire_s = 1'b0;
        if ((state_r == AACK) || (state_r == WACK)) begin
            ack_fall_s   = ack_seen_r & ~b_ack;
            ack_expire_s = (cnt_r == ACK_LAST);
        end else begin
            ack_fall_s   = 1'b0;
            ack_expire_s = 1'b0;
        end
    end

    // Transaction sequencer with all bus and requester outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            ack_seen_r <= 1'b0;
            addr_sh_r  <= '0;
            wdata_sh_r <= '0;
            rx_sh_r    <= '0;
            m_ready    <= 1'b1;
            m_rdata    <= '0;
            m_rvalid   <= 1'b0;
            m_done     <= 1'b0;
            m_err      <= 1'b0;
            b_sel      <= 1'b0;
            b_rw       <= 1'b0;
            b_bus_out  <= 1'b0;
        end else begin
            m_rvalid <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    // m_ready is still low in the completion-pulse cycle, so
                    // the bus stays selected for exactly that one extra cycle.
                    if (m_valid && m_ready) begin
                        state_r    <= ADDR;
                        m_ready    <= 1'b0;
                        b_sel      <= 1'b1;
                        b_rw       <= m_rw;
                        b_bus_out  <= m_addr[0];
                        addr_sh_r  <= {1'b0, m_addr[ADDR_WIDTH-1:1]};
                        wdata_sh_r <= m_wdata;
                        cnt_r      <= CW'(1);
                    end else begin
                        m_ready   <= 1'b1;
                        b_sel     <= 1'b0;
                        b_rw      <= 1'b0;
                        b_bus_out <= 1'b0;
                    end
                end
                ADDR: begin
                    if (cnt_r == ADDR_LAST) begin
                        state_r    <= AACK;
                        b_bus_out  <= 1'b0;
                        cnt_r      <= '0;
                        ack_seen_r <= 1'b0;
                    end else begin
                        b_bus_out <= addr_sh_r[0];
                        addr_sh_r <= {1'b0, addr_sh_r[ADDR_WIDTH-1:1]};
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                AACK, WACK: begin
                    if (ack_fall_s) begin
                        cnt_r <= '0;
                        if (state_r == WACK) begin
                            m_done  <= 1'b1;
                            state_r <= IDLE;
                        end else if (b_rw) begin
                            state_r    <= WDATA;
                            b_bus_out  <= wdata_sh_r[0];
                            wdata_sh_r <= {1'b0, wdata_sh_r[DATA_WIDTH-1:1]};
                            cnt_r      <= CW'(1);
                        end else if (RD_SKEW == 0) begin
                            state_r <= RDATA;
                        end else begin
                            state_r <= RSKEW;
                        end
                    end else if (ack_expire_s) begin
                        m_err   <= 1'b1;
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r      <= cnt_r + CW'(1);
                        ack_seen_r <= ack_seen_r | b_ack;
                    end
                end
                WDATA: begin
                    if (cnt_r == DATA_LAST) begin
                        state_r    <= WACK;
                        b_bus_out  <= 1'b0;
                        cnt_r      <= '0;
                        ack_seen_r <= 1'b0;
                    end else begin
                        b_bus_out  <= wdata_sh_r[0];
                        wdata_sh_r <= {1'b0, wdata_sh_r[DATA_WIDTH-1:1]};
                        cnt_r      <= cnt_r + CW'(1);
                    end
                end
                RSKEW: begin
                    if (cnt_r == SKEW_LAST) begin
                        state_r <= RDATA;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RDATA: begin
                    rx_sh_r <= {b_bus_in, rx_sh_r[DATA_WIDTH-1:1]};
                    if (cnt_r == RX_LAST) begin
                        m_rdata  <= {b_bus_in, rx_sh_r[DATA_WIDTH-1:1]};
                        m_rvalid <= 1'b1;
                        state_r  <= IDLE;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table of directed transactions plus random traffic,
// each checked cycle by cycle against a timeline built from the bus protocol rules.
module tb_bus_master_port;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int TO = 15;
    localparam int SK = 1;
    localparam int NC = 128;

    localparam logic [6:0] IDLEV  = 7'b1000000;
    localparam int K_DONE = 0;
    localparam int K_RVAL = 1;
    localparam int K_ERR  = 2;

    logic          clk;
    logic          rst_n;
    logic          m_valid;
    logic          m_ready;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_done;
    logic          m_err;
    logic          b_sel;
    logic          b_rw;
    logic          b_bus_out;
    logic          b_bus_in;
    logic          b_ack;

    bus_master_port #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO), .RD_SKEW(SK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready),
        .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_rvalid(m_rvalid), .m_done(m_done), .m_err(m_err), .b_sel(b_sel),
        .b_rw(b_rw), .b_bus_out(b_bus_out), .b_bus_in(b_bus_in), .b_ack(b_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;   // value the slave returns on a read
        int            da, la;  // address ack: idle cycles before, cycles high
        int            db, lb;  // write ack: idle cycles before, cycles high
        bit            noisy;   // random m_valid/request junk while busy
        bit            b2b;     // issue directly in the cycle after completion
        int            rst_bit; // reset while this write data bit is on the bus
        int            kind;    // expected outcome, -1 = derive from timing rules
    } txn_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_rdata = '0;

    task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {m_ready, b_sel, b_rw, b_bus_out, m_rvalid, m_done, m_err};
    endfunction

    function automatic logic [6:0] busy(input logic rw, input logic bit_out);
        return {1'b0, 1'b1, rw, bit_out, 3'b000};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", i, {25'd0, outs()}, {25'd0, IDLEV});
            m_valid = 1'b0;
        end
    endtask

    // Build the expected timeline from the protocol rules, then play it.
    task automatic run_txn(input txn_t t);
        logic [6:0] exp_o [NC];
        logic       ack_in [NC];
        logic       din_in [NC];
        int e, f, e2, f2, c, kind, rcyc;
        bit ok;
        for (int n = 0; n < NC; n++) begin
            exp_o[n] = IDLEV; ack_in[n] = 1'b0; din_in[n] = 1'b0;
        end
        rcyc = -1;
        for (int i = 0; i < AW; i++) exp_o[1+i] = busy(t.rw, t.addr[i]);
        e = AW + 1;
        for (int k = t.da; k < t.da + t.la; k++) if (e + k < NC) ack_in[e+k] = 1'b1;
        ok = (t.la >= 1) && (t.da + t.la <= TO - 1);
        if (!ok) begin
            c = e + TO; kind = K_ERR;
            for (int n = e; n < c; n++) exp_o[n] = busy(t.rw, 1'b0);
        end else begin
            f = e + t.da + t.la;
            for (int n = e; n <= f; n++) exp_o[n] = busy(t.rw, 1'b0);
            if (t.rw) begin
                for (int j = 0; j < DW; j++) exp_o[f+1+j] = busy(1'b1, t.wdata[j]);
                if (t.rst_bit >= 0) rcyc = f + 1 + t.rst_bit;
                e2 = f + 1 + DW;
                for (int k = t.db; k < t.db + t.lb; k++) if (e2 + k < NC) ack_in[e2+k] = 1'b1;
                if ((t.lb >= 1) && (t.db + t.lb <= TO - 1)) begin
                    f2 = e2 + t.db + t.lb; c = f2 + 1; kind = K_DONE;
                end else begin
                    c = e2 + TO; kind = K_ERR;
                end
                for (int n = e2; n < c; n++) exp_o[n] = busy(1'b1, 1'b0);
            end else begin
                for (int n = f + 1; n <= f + SK + DW; n++) exp_o[n] = busy(1'b0, 1'b0);
                for (int j = 0; j < DW; j++) din_in[f+1+SK+j] = t.rdata[j];
                c = f + SK + DW + 1; kind = K_RVAL;
            end
        end
        if (t.kind >= 0) kind = t.kind;
        exp_o[c] = busy(t.rw, 1'b0) | ((kind == K_RVAL) ? 7'b0000100 :
                                       (kind == K_DONE) ? 7'b0000010 : 7'b0000001);
        exp_o[c+1] = IDLEV;

        chk("accept_ready", 0, {25'd0, outs()}, {25'd0, IDLEV});
        m_valid = 1'b1; m_rw = t.rw; m_addr = t.addr; m_wdata = t.wdata;
        b_ack = 1'b0; b_bus_in = 1'b0;
        for (int n = 1; n <= c + 1; n++) begin
            @(negedge clk);
            if (n == c && kind == K_RVAL) model_rdata = t.rdata;
            chk("outputs", n, {25'd0, outs()}, {25'd0, exp_o[n]});
            if (n >= c) chk("m_rdata", n, {24'd0, m_rdata}, {24'd0, model_rdata});
            if (n == rcyc) begin
                #2 rst_n = 1'b0;
                #1;
                model_rdata = '0;
                chk("reset_outputs", n, {25'd0, outs()}, {25'd0, IDLEV});
                chk("reset_rdata", n, {24'd0, m_rdata}, 32'd0);
                m_valid = 1'b0; b_ack = 1'b0; b_bus_in = 1'b0;
                @(negedge clk);
                chk("in_reset", n + 1, {25'd0, outs()}, {25'd0, IDLEV});
                rst_n = 1'b1;
                return;
            end
            b_ack = ack_in[n]; b_bus_in = din_in[n];
            if (n < c) begin
                m_valid = t.noisy ? 1'($urandom) : 1'b1;
                m_rw    = 1'($urandom);
                m_addr  = AW'($urandom);
                m_wdata = DW'($urandom);
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    txn_t tbl [10];
    txn_t rt;

    initial begin
        // rw addr wdata rdata da la db lb noisy b2b rst kind
        tbl[0] = '{1'b1, 15'h0A4B, 8'hC3, 8'h00, 2, 1, 1, 2, 1'b0, 1'b0, -1, K_DONE};
        tbl[1] = '{1'b0, 15'h1235, 8'h00, 8'h5A, 0, 3, 0, 0, 1'b0, 1'b0, -1, K_RVAL};
        tbl[2] = '{1'b0, 15'h7FFF, 8'h00, 8'hA5, 0, 0, 0, 0, 1'b1, 1'b0, -1, K_ERR};
        tbl[3] = '{1'b1, 15'h2222, 8'h96, 8'h00, 1, 1, 0, 1, 1'b0, 1'b0,  3, K_DONE};
        tbl[4] = '{1'b1, 15'h4001, 8'h3C, 8'h00, 0, 2, 2, 2, 1'b0, 1'b0, -1, K_DONE};
        tbl[5] = '{1'b0, 15'h0F0F, 8'h00, 8'h81, 1, 1, 0, 0, 1'b1, 1'b1, -1, K_RVAL};
        tbl[6] = '{1'b1, 15'h1111, 8'h55, 8'h00, 0, 1, 0, 40, 1'b0, 1'b0, -1, K_ERR};
        tbl[7] = '{1'b1, 15'h6BCD, 8'hE7, 8'h00, 13, 1, 0, 14, 1'b0, 1'b0, -1, K_DONE};
        tbl[8] = '{1'b0, 15'h0001, 8'h00, 8'h77, 14, 1, 0, 0, 1'b0, 1'b0, -1, K_ERR};
        tbl[9] = '{1'b0, 15'h5555, 8'h00, 8'hFF, 5, 2, 0, 0, 1'b1, 1'b1, -1, K_RVAL};

        rst_n = 1'b0; m_valid = 1'b0; m_rw = 1'b0; m_addr = '0; m_wdata = '0;
        b_ack = 1'b0; b_bus_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 0, {25'd0, outs()}, {25'd0, IDLEV});
        chk("reset_rdata", 0, {24'd0, m_rdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (!tbl[i].b2b) idle_cycles(2);
            run_txn(tbl[i]);
        end

        for (int k = 0; k < 40; k++) begin
            rt.rw    = 1'($urandom);
            rt.addr  = AW'($urandom);
            rt.wdata = DW'($urandom);
            rt.rdata = DW'($urandom);
            rt.da    = $urandom_range(0, 8);
            rt.la    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            rt.db    = $urandom_range(0, 8);
            rt.lb    = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(1, 8);
            rt.noisy = 1'($urandom);
            rt.b2b   = 1'($urandom);
            rt.rst_bit = -1;
            rt.kind  = -1;
            if (!rt.b2b) idle_cycles($urandom_range(0, 2));
            run_txn(rt);
        end

        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
